// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam int DIV_WIDTH = 4;
    localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

    // Step counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational N-bit subtractor: minuend + ~subtrahend + 1 as a ripple of full adders.
module div_sub_stage #(
    parameter int N = 5
) (
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (minuend[i]),
            .b    (~subtrahend[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Carry-out set means minuend >= subtrahend.
    assign no_borrow = carry[N];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the cell the trial subtractor is chained from.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/four_bit_divider.sv
// Sequential unsigned restoring divider, one shift/trial-subtract per clock.
// Optional DIV_ZERO_DETECT_EN: divisor 0 skips RUN and flags div_by_zero.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | WIDTH shift/subtract steps under the step counter
//   DONE  | results published, done pulse
module four_bit_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    div_state_t state, state_next;

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             no_borrow;
    logic             accept;
    logic             last_step;
    logic             zero_div;
    logic             unused_bits;

    // {R,Q} << 1; R's top bit is always 0 after a step, so it drops off.
    assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    div_sub_stage #(.N(WIDTH + 1)) u_sub (
        .minuend    (rem_shift),
        .subtrahend ({1'b0, dsr_q}),
        .diff       (trial),
        .no_borrow  (no_borrow)
    );

    assign rem_step    = no_borrow ? trial : rem_shift;
    assign quo_step    = {quo_q[WIDTH-2:0], no_borrow};
    assign accept      = (state == IDLE) && start;
    assign last_step   = (state == RUN) && (cnt == CW'(1));
    assign unused_bits = rem_q[WIDTH];

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div = accept && (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (zero_div) begin
                    state_next = DONE;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

    logic dz_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz_q      <= 1'b0;
        end else begin
            if (accept) begin
                quo_q <= dividend;
                dsr_q <= divisor;
                rem_q <= '0;
                cnt   <= CNT_INIT;
            end else if (state == RUN) begin
                quo_q <= quo_step;
                rem_q <= rem_step;
                cnt   <= cnt - CW'(1);
            end

            if (last_step) begin
                quotient  <= quo_step;
                remainder <= rem_step[WIDTH-1:0];
                dz_q      <= 1'b0;
            end else if (zero_div) begin
                quotient  <= '1;
                remainder <= dividend;
                dz_q      <= 1'b1;
            end
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_divider.sv
// Self-checking bench for four_bit_divider: cycle-level behavioural model plus directed literals.
module tb_four_bit_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    four_bit_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the outputs must be in the cycle following each edge.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dz = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] p_q = '0;
    logic [W-1:0] p_r = '0;
    logic         p_dz = 1'b0;
    int           m_left = 0;
    int           acc_cnt = 0;
    int           cyc = 0;
    int           acc_cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
                m_q = '0; m_r = '0; m_left = 0;
            end else if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_q = p_q; m_r = p_r; m_dz = p_dz; m_done = 1'b1;
                end
            end else if (start) begin
                acc_cnt++;
                acc_cyc = cyc;
                if (divisor == 0) begin
                    p_q = '1;
                    p_r = dividend;
                end else begin
                    p_q = dividend / divisor;
                    p_r = dividend % divisor;
                end
                p_dz   = 1'b0;
                m_busy = 1'b1;
                m_left = W;
`ifdef DIV_ZERO_DETECT_EN
                if (divisor == 0) begin
                    p_dz = 1'b1;
                    m_left = 0;
                    m_q = p_q; m_r = p_r; m_dz = p_dz; m_done = 1'b1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", div_by_zero, m_dz);
        end
    end

    // Counts negedges from first_cyc; returns the cycle in which done is seen, -1 on timeout.
    task automatic wait_done(input int first_cyc, output int at);
        at = -1;
        for (int n = first_cyc; n < first_cyc + 20; n++) begin
            @(negedge clk);
            if (done) begin
                at = n;
                return;
            end
        end
    endtask

    task automatic run_div(input int a, input int b, input int eq, input int er,
                           input int edz, input int elat);
        int at;
        @(posedge clk); #1;
        dividend = W'(a); divisor = W'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, at);
        chk($sformatf("lat_%0d_%0d", a, b), at, elat);
        chk($sformatf("q_%0d_%0d", a, b), quotient, eq);
        chk($sformatf("r_%0d_%0d", a, b), remainder, er);
        chk($sformatf("dz_%0d_%0d", a, b), div_by_zero, edz);
    endtask

    initial begin
        int at;
        int k;
        int prev_acc;

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_q", quotient, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_div(13, 3, 4, 1, 0, 5);
        run_div(15, 1, 15, 0, 0, 5);
        run_div(5, 7, 0, 5, 0, 5);
        run_div(4, 4, 1, 0, 0, 5);
`ifdef DIV_ZERO_DETECT_EN
        run_div(9, 0, 15, 9, 1, 1);
`else
        run_div(9, 0, 15, 9, 0, 5);
`endif

        // Start while busy is dropped, not queued.
        @(posedge clk); #1;
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        dividend = 4'd8; divisor = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = '0; divisor = '0;
        wait_done(3, at);
        chk("ign_lat", at, 5);
        chk("ign_q", quotient, 4);
        chk("ign_r", remainder, 1);
        dividend = 4'd8; divisor = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(7, at);
        chk("restart_cycle", at, 11);
        chk("restart_q", quotient, 4);

        // Reset mid-operation.
        @(posedge clk); #1;
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_busy", busy, 0);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            k += int'(done);
        end
        chk("abort_no_done", k, 0);
        run_div(14, 3, 4, 2, 0, 5);

        // Exhaustive sweep, start held so each is accepted at the earliest edge.
        prev_acc = -1;
        @(posedge clk); #1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                dividend = W'(a); divisor = W'(b); start = 1'b1;
                k = acc_cnt;
                for (int t = 0; t < 20; t++) begin
                    @(posedge clk); #1;
                    if (acc_cnt != k) break;
                end
                chk("sweep_accept", acc_cnt - k, 1);
                if (prev_acc >= 0) chk("sweep_gap", acc_cyc - prev_acc, W + 2);
                prev_acc = acc_cyc;
            end
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Random traffic including zero divisors, starts while busy and sporadic resets.
        for (int i = 0; i < 2000; i++) begin
            start    = ($urandom_range(0, 2) != 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            reset    = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
